// File: rtl/edge_pkg.sv
// Shared constants and types for the window builder and its helpers.
package edge_pkg;

    localparam int ROW_PIXELS    = 20;
    localparam int BIT_PER_PIXEL = 8;
    localparam int COL_W         = 5;

    // Left column of the right-most window in a row.
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_PIXELS - 3);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        EMIT     = 2'd1,
        WAIT_ROW = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/window_mux.sv
// Combinational 3x3 window selection from three stored rows at a given column.
module window_mux
    import edge_pkg::*;
(
    input  logic [ROW_PIXELS-1:0][BIT_PER_PIXEL-1:0] i_row0,
    input  logic [ROW_PIXELS-1:0][BIT_PER_PIXEL-1:0] i_row1,
    input  logic [ROW_PIXELS-1:0][BIT_PER_PIXEL-1:0] i_row2,
    input  logic [COL_W-1:0]                         i_col,
    output logic [8:0][BIT_PER_PIXEL-1:0]            o_window
);

    // Pick three adjacent pixels from each row, top row first.
    always_comb begin
        o_window = '0;
        for (int k = 0; k < 3; k++) begin
            o_window[k]     = i_row0[i_col + COL_W'(k)];
            o_window[3 + k] = i_row1[i_col + COL_W'(k)];
            o_window[6 + k] = i_row2[i_col + COL_W'(k)];
        end
    end

endmodule

// File: rtl/window_builder.sv
// Row buffer and column sweeper feeding 3x3 windows to the edge kernel.
module window_builder
    import edge_pkg::*;
(
    input  logic                                     clk,
    input  logic                                     n_rst,
    input  logic                                     clear,
    input  logic [ROW_PIXELS-1:0][BIT_PER_PIXEL-1:0] row_in,
    input  logic                                     row_last,
    input  logic                                     row_valid,
    output logic                                     row_ready,
    output logic [8:0][BIT_PER_PIXEL-1:0]            window,
    output logic [COL_W-1:0]                         win_col,
    output logic                                     win_valid,
    input  logic                                     win_ready,
    output logic                                     frame_done
);

    state_t                                   r_state;
    state_t                                   w_state_nxt;
    logic [ROW_PIXELS-1:0][BIT_PER_PIXEL-1:0] r_row0;
    logic [ROW_PIXELS-1:0][BIT_PER_PIXEL-1:0] r_row1;
    logic [ROW_PIXELS-1:0][BIT_PER_PIXEL-1:0] r_row2;
    logic [1:0]                               r_row_cnt;
    logic [1:0]                               w_row_cnt_nxt;
    logic [COL_W-1:0]                         r_col;
    logic [COL_W-1:0]                         w_col_nxt;
    logic                                     r_last_seen;
    logic                                     w_last_nxt;
    logic                                     w_shift;
    logic                                     w_accept;
    logic                                     w_win_fire;

    // Output strobes depend only on the registered state, so no input feeds them directly.
    always_comb begin
        row_ready  = 1'b0;
        win_valid  = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            FILL:     row_ready  = 1'b1;
            EMIT:     win_valid  = 1'b1;
            WAIT_ROW: row_ready  = 1'b1;
            DONE:     frame_done = 1'b1;
            default:  row_ready  = 1'b0;
        endcase
    end

    assign w_accept   = row_valid & row_ready;
    assign w_win_fire = win_valid & win_ready;

    // Next-state, row counter, column and last-row flag.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_cnt_nxt = r_row_cnt;
        w_col_nxt     = r_col;
        w_last_nxt    = r_last_seen;
        w_shift       = 1'b0;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_shift       = 1'b1;
                    w_last_nxt    = row_last;
                    w_row_cnt_nxt = r_row_cnt + 2'd1;
                    if (row_last && (w_row_cnt_nxt != 2'd3)) begin
                        // Frame ended before three rows: nothing to emit.
                        w_state_nxt = DONE;
                    end else if (w_row_cnt_nxt == 2'd3) begin
                        w_state_nxt = EMIT;
                        w_col_nxt   = '0;
                    end else begin
                        w_state_nxt = FILL;
                    end
                end else begin
                    w_state_nxt = FILL;
                end
            end
            EMIT: begin
                if (w_win_fire) begin
                    if (r_col == COL_LAST) begin
                        w_state_nxt = r_last_seen ? DONE : WAIT_ROW;
                    end else begin
                        w_col_nxt = r_col + 5'd1;
                    end
                end else begin
                    w_state_nxt = EMIT;
                end
            end
            WAIT_ROW: begin
                if (w_accept) begin
                    w_shift     = 1'b1;
                    w_last_nxt  = row_last;
                    w_state_nxt = EMIT;
                    w_col_nxt   = '0;
                end else begin
                    w_state_nxt = WAIT_ROW;
                end
            end
            DONE: begin
                w_row_cnt_nxt = 2'd0;
                w_last_nxt    = 1'b0;
                w_col_nxt     = '0;
                w_state_nxt   = FILL;
            end
            default: begin
                w_state_nxt   = FILL;
                w_row_cnt_nxt = 2'd0;
                w_col_nxt     = '0;
                w_last_nxt    = 1'b0;
            end
        endcase
    end

    // State, counters and row storage; clear behaves like reset but synchronously.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= FILL;
            r_row0      <= '0;
            r_row1      <= '0;
            r_row2      <= '0;
            r_row_cnt   <= 2'd0;
            r_col       <= '0;
            r_last_seen <= 1'b0;
        end else if (clear) begin
            r_state     <= FILL;
            r_row0      <= '0;
            r_row1      <= '0;
            r_row2      <= '0;
            r_row_cnt   <= 2'd0;
            r_col       <= '0;
            r_last_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_cnt   <= w_row_cnt_nxt;
            r_col       <= w_col_nxt;
            r_last_seen <= w_last_nxt;
            if (w_shift) begin
                r_row0 <= r_row1;
                r_row1 <= r_row2;
                r_row2 <= row_in;
            end
        end
    end

    window_mux u_mux (
        .i_row0   (r_row0),
        .i_row1   (r_row1),
        .i_row2   (r_row2),
        .i_col    (r_col),
        .o_window (window)
    );

    assign win_col = r_col;

endmodule

// File: tb/tb_window_builder.sv
// Self-checking bench for window_builder: frame-level model plus directed literal checks.
module tb_window_builder;
    import edge_pkg::*;

    logic                        clk = 1'b0;
    logic                        n_rst;
    logic                        clear;
    logic [19:0][7:0]            row_in;
    logic                        row_last;
    logic                        row_valid;
    logic                        row_ready;
    logic [8:0][7:0]             window;
    logic [4:0]                  win_col;
    logic                        win_valid;
    logic                        win_ready;
    logic                        frame_done;

    int checks   = 0;
    int failures = 0;

    window_builder dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .row_in     (row_in),
        .row_last   (row_last),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .window     (window),
        .win_col    (win_col),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [8:0][7:0] win;
        int              col;
        bit              fin;
    } exp_t;

    exp_t            q[$];
    logic [19:0][7:0] m_rows[3];
    int              m_nrows  = 0;
    bit              exp_done = 1'b0;
    bit              stalled  = 1'b0;
    logic [8:0][7:0] prev_win;
    logic [4:0]      prev_col;

    function automatic logic [8:0][7:0] mk_win(input logic [19:0][7:0] a, input logic [19:0][7:0] b,
                                               input logic [19:0][7:0] c, input int col);
        logic [8:0][7:0] w;
        for (int k = 0; k < 3; k++) begin
            w[k]     = a[col + k];
            w[3 + k] = b[col + k];
            w[6 + k] = c[col + k];
        end
        return w;
    endfunction

    // Compare outputs against the model every cycle, then advance the model.
    always @(negedge clk) begin
        bit   next_done;
        exp_t e;
        if (!n_rst) begin
            q.delete();
            m_nrows  = 0;
            exp_done = 1'b0;
            stalled  = 1'b0;
            chk("rst_row_ready", 72'(row_ready), 72'd1);
            chk("rst_win_valid", 72'(win_valid), 72'd0);
            chk("rst_frame_done", 72'(frame_done), 72'd0);
            chk("rst_window", window, 72'd0);
            chk("rst_win_col", 72'(win_col), 72'd0);
        end else begin
            chk("m_frame_done", 72'(frame_done), 72'(exp_done));
            chk("m_row_ready", 72'(row_ready), 72'((q.size() == 0) && !exp_done));
            chk("m_win_valid", 72'(win_valid), 72'(q.size() != 0));
            if (win_valid && stalled) begin
                chk("m_hold_window", window, prev_win);
                chk("m_hold_col", 72'(win_col), 72'(prev_col));
            end
            if (win_valid && q.size() != 0) begin
                chk("m_window", window, q[0].win);
                chk("m_win_col", 72'(win_col), 72'(q[0].col));
            end
            next_done = 1'b0;
            if (clear) begin
                q.delete();
                m_nrows = 0;
            end else begin
                if (win_valid && win_ready && q.size() != 0) begin
                    e = q.pop_front();
                    if (e.fin) next_done = 1'b1;
                end
                if (row_valid && row_ready) begin
                    m_rows[0] = m_rows[1];
                    m_rows[1] = m_rows[2];
                    m_rows[2] = row_in;
                    if (m_nrows < 3) m_nrows++;
                    if (row_last && m_nrows < 3) begin
                        next_done = 1'b1;
                        m_nrows   = 0;
                    end else if (m_nrows == 3) begin
                        for (int c = 0; c <= ROW_PIXELS - 3; c++) begin
                            e.win = mk_win(m_rows[0], m_rows[1], m_rows[2], c);
                            e.col = c;
                            e.fin = row_last && (c == ROW_PIXELS - 3);
                            q.push_back(e);
                        end
                        if (row_last) m_nrows = 0;
                    end
                end
            end
            stalled  = win_valid && !win_ready;
            prev_win = window;
            prev_col = win_col;
            exp_done = next_done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input int r, input bit last);
        bit done;
        for (int c = 0; c < 20; c++) row_in[c] = 8'(32 * r + c);
        row_last  = last;
        row_valid = 1'b1;
        done      = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (row_ready) done = 1'b1;
            tick();
        end
        if (!done) chk("row_accept_timeout", 72'd0, 72'd1);
        row_valid = 1'b0;
        row_last  = 1'b0;
    endtask

    task automatic wait_col(input int col);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (win_valid && win_col == 5'(col)) hit = 1'b1;
            else tick();
        end
        if (!hit) chk("wait_col_timeout", 72'd0, 72'(col));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && win_valid; i++) tick();
        chk("drain_end", 72'(win_valid), 72'd0);
    endtask

    localparam logic [71:0] W_FIRST = {8'd66, 8'd65, 8'd64, 8'd34, 8'd33, 8'd32, 8'd2, 8'd1, 8'd0};
    localparam logic [71:0] W_LAST  = {8'd83, 8'd82, 8'd81, 8'd51, 8'd50, 8'd49, 8'd19, 8'd18, 8'd17};
    localparam logic [71:0] W_FEND  = {8'd98, 8'd97, 8'd96, 8'd66, 8'd65, 8'd64, 8'd34, 8'd33, 8'd32};
    localparam logic [71:0] W_BP4   = {8'd102, 8'd101, 8'd100, 8'd70, 8'd69, 8'd68, 8'd38, 8'd37, 8'd36};

    initial begin
        int n;
        bit seen;
        n_rst     = 1'b0;
        clear     = 1'b0;
        row_in    = '0;
        row_last  = 1'b0;
        row_valid = 1'b0;
        win_ready = 1'b1;
        repeat (3) tick();
        chk("reset_row_ready", 72'(row_ready), 72'd1);
        chk("reset_window", window, 72'd0);
        n_rst = 1'b1;
        tick();

        // Fill and sweep
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        send_row(2, 1'b0);
        chk("first_valid", 72'(win_valid), 72'd1);
        chk("first_window", window, W_FIRST);
        chk("first_col", 72'(win_col), 72'd0);
        n = 0;
        for (int i = 0; i < 40 && win_valid; i++) begin
            if (win_col == 5'd17) chk("last_window", window, W_LAST);
            n++;
            tick();
        end
        chk("sweep_count", 72'(n), 72'd18);
        chk("wait_row_ready", 72'(row_ready), 72'd1);

        // Frame end with backpressure
        send_row(3, 1'b1);
        chk("fend_row_ready", 72'(row_ready), 72'd0);
        chk("fend_first_window", window, W_FEND);
        wait_col(4);
        win_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_col", 72'(win_col), 72'd4);
            chk("bp_window", window, W_BP4);
        end
        win_ready = 1'b1;
        tick();
        chk("bp_resume_col", 72'(win_col), 72'd5);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (frame_done) seen = 1'b1;
            else tick();
        end
        chk("fend_done_seen", 72'(seen), 72'd1);
        chk("fend_done_row_ready", 72'(row_ready), 72'd0);
        tick();
        chk("fend_done_pulse", 72'(frame_done), 72'd0);
        chk("fend_ready_back", 72'(row_ready), 72'd1);

        // Short frame
        send_row(4, 1'b0);
        send_row(5, 1'b1);
        chk("short_done", 72'(frame_done), 72'd1);
        chk("short_no_valid", 72'(win_valid), 72'd0);
        tick();
        chk("short_done_pulse", 72'(frame_done), 72'd0);
        chk("short_ready", 72'(row_ready), 72'd1);

        // Mid-EMIT synchronous clear
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        send_row(2, 1'b0);
        wait_col(9);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_win_valid", 72'(win_valid), 72'd0);
        chk("clr_row_ready", 72'(row_ready), 72'd1);
        chk("clr_win_col", 72'(win_col), 72'd0);
        chk("clr_window", window, 72'd0);
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        send_row(2, 1'b0);
        chk("clr_refill_col", 72'(win_col), 72'd0);
        chk("clr_refill_window", window, W_FIRST);
        drain();

        // Mid-EMIT asynchronous reset
        send_row(3, 1'b0);
        wait_col(9);
        n_rst = 1'b0;
        #1;
        chk("arst_win_valid", 72'(win_valid), 72'd0);
        chk("arst_row_ready", 72'(row_ready), 72'd1);
        tick();
        tick();
        n_rst = 1'b1;
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        send_row(2, 1'b0);
        chk("arst_refill_col", 72'(win_col), 72'd0);
        chk("arst_refill_window", window, W_FIRST);
        drain();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_builder.md
# window_builder

Downstream neighbour of the pixel controller. Accepts whole greyscale pixel rows (strips of `ROW_PIXELS` pixels) through a valid/ready handshake and holds the three most recent rows. Sweeps those rows column by column, presenting one 3x3 window per accepted transfer to the edge-detection kernel. Handles frame start, backpressure and frame end, so the kernel only ever sees complete windows.

## Interface
- `ROW_PIXELS`, 20, pixels per row strip; must be at least 3.
- `BIT_PER_PIXEL`, 8, bits per greyscale pixel.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous restart; highest priority after `n_rst`.
- `row_in`  in  [ROW_PIXELS-1:0][BIT_PER_PIXEL-1:0]  incoming row; index 0 is the leftmost pixel.
- `row_last`  in  1  marks `row_in` as the last row of the frame.
- `row_valid`  in  1  `row_in` and `row_last` are valid.
- `row_ready`  out  1  block can accept a row this cycle.
- `window`  out  [8:0][BIT_PER_PIXEL-1:0]  3x3 window in row-major order. `window[0]` = top row at column `win_col`; `window[8]` = bottom row at column `win_col+2`.
- `win_col`  out  5  left column of the current window, 0..ROW_PIXELS-3.
- `win_valid`  out  1  `window` and `win_col` are valid.
- `win_ready`  in  1  consumer accepts the window.
- `frame_done`  out  1  one-cycle pulse at end of frame.

## Operation
- **Row storage.** Three row registers: `r0` (top), `r1`, `r2` (bottom). A row is accepted on any edge where `row_valid & row_ready`. On acceptance the rows shift up: `r0<=r1`, `r1<=r2`, `r2<=row_in`.
- **Row count.** `row_cnt` is 0..3 and saturates at 3. `last_seen` latches `row_last` on each accepted row.
- **FILL**
  - `row_ready=1`, `win_valid=0`.
  - On acceptance, `row_cnt++`.
  - If the accepted row has `row_last=1` and the resulting count is below 3: go to DONE. The frame is too short and produces no windows.
  - Else, when the count reaches 3: go to EMIT with `col=0`.
- **EMIT**
  - `row_ready=0`, `win_valid=1`.
  - On `win_valid & win_ready`: if `col==ROW_PIXELS-3`, go to DONE when `last_seen`, else to WAIT_ROW. Otherwise `col++`.
- **WAIT_ROW**
  - `row_ready=1`, `win_valid=0`.
  - On acceptance: shift rows, latch `last_seen`, go to EMIT with `col=0`.
- **DONE**
  - `frame_done=1` for exactly one cycle; `row_ready=0`.
  - Clear `row_cnt`, `last_seen` and `col`, then go to FILL.
- **Window composition.** `window` is a combinational selection from `r0..r2` using `col`. `win_col` equals `col`.
- **Width rules.** `col` is 5 bits and never exceeds `ROW_PIXELS-3`. Pixels pass through unmodified; there is no arithmetic on pixel data.
- **Reset / clear.** `n_rst` low (asynchronous), or `clear` high at an edge, forces:
  - state FILL;
  - `r0..r2`, `row_cnt`, `col`, `last_seen` all 0.
  This holds from any state, including mid-EMIT. Any in-flight window is dropped.
- **Reset values of outputs:** `row_ready=1`, `win_valid=0`, `frame_done=0`, `window=0`, `win_col=0`.
- **`row_valid` outside FILL/WAIT_ROW.** Ignored; the source must hold its row until `row_ready`.

## Timing
- **First window.** `win_valid` rises the cycle after the third row is accepted.
- **Throughput.** With `win_ready` held high:
  - `ROW_PIXELS-2` windows (18 by default) on consecutive cycles;
  - then at least 1 cycle in WAIT_ROW.
  - A frame of H rows (H≥3) yields `(H-2)*(ROW_PIXELS-2)` windows.
- **Backpressure.** While `win_valid & !win_ready`, `window` and `win_col` are held stable.
- **Frame end.** `frame_done` pulses the cycle after:
  - the final window handshake; or
  - acceptance of a short frame's last row.
  `row_ready` returns to 1 the cycle after the pulse.
- **No combinational paths** from `row_valid` to `row_ready`, or from `win_ready` to `win_valid`.

## Structure
- **Shared package** (`edge_pkg`): `BIT_PER_PIXEL`, `ROW_PIXELS`, and the state typedef `{FILL, EMIT, WAIT_ROW, DONE}`.
- **Sub-module** `window_mux`: combinational 3x3 selection from the three rows by `col`. FSM, row registers and column counter are inline.

## Test plan
- **Reset.** Pulse `n_rst` low with `row_valid=0` -> `row_ready=1`, `win_valid=0`, `frame_done=0`, `window=0`, `win_col=0`.
- **Fill and sweep.** Feed rows where pixel(r,c)=32r+c for r=0..2, `win_ready=1` ->
  - first window {0,1,2,32,33,34,64,65,66} with `win_col=0`;
  - 18 windows on consecutive cycles;
  - last window {17,18,19,49,50,51,81,82,83} with `win_col=17`.
- **Backpressure.** Drop `win_ready` for 5 cycles when `win_col=4` -> `window` and `win_col=4` unchanged; the sweep then resumes with `win_col=5`.
- **Frame end.** After the 3-row sweep, feed row 3 with `row_last=1` ->
  - `row_ready=0` during EMIT;
  - first window {32,33,34,64,65,66,96,97,98};
  - after 18 windows, `frame_done` is a single-cycle pulse, then `row_ready=1`.
- **Short frame.** Feed 2 rows, the second with `row_last=1` -> `win_valid` never asserts; `frame_done` pulses the cycle after the second acceptance.
- **Mid-EMIT restart.** At `win_col=9`, assert `clear` for one edge (repeat the run with async `n_rst`) -> next cycle `win_valid=0`, `row_ready=1`. A fresh 3-row fill then produces `win_col=0` again.
